// File: rtl/serial_sub.sv
// Nibble-serial subtractor: d = a - b - bin, with borrow-out and signed overflow.
// Latency: WIDTH/4 cycles from the accepting edge to out_valid.
// Backpressure: one operation in flight; result held in DONE until out_ready, in_ready low meanwhile.
module serial_sub #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] d_q;
    logic             brw_q;
    logic             bout_q;
    logic             ovf_q;
    logic [IW-1:0]    idx_q;

    logic [IW+1:0]    base;
    logic [3:0]       an;
    logic [3:0]       bn;
    logic [3:0]       g;
    logic [3:0]       p;
    logic [3:0]       c;
    logic             c4;
    logic [3:0]       diff;
    logic             last;

    // Current nibble is always taken from the captured operands.
    assign base = {idx_q, 2'b00};
    assign an   = a_q[base +: 4];
    assign bn   = b_q[base +: 4];
    assign g    = ~an & bn;
    assign p    = ~(an ^ bn);
    assign last = (idx_q == IW'(NIB - 1));

    // Borrow lookahead across the four bits of the nibble.
    assign c[0] = brw_q;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign diff = an ^ bn ^ c;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            d_q    <= '0;
            brw_q  <= 1'b0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
            idx_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        brw_q <= bin;
                        d_q   <= '0;
                        idx_q <= '0;
                    end
                end
                RUN: begin
                    d_q[base +: 4] <= diff;
                    brw_q          <= c4;
                    if (last) begin
                        idx_q  <= '0;
                        bout_q <= c4;
                        // diff[3] is the result MSB being written on this edge.
                        ovf_q  <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (diff[3] ^ a_q[WIDTH-1]);
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign d    = d_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule
